// File: rtl/mipi_rx_raw_unpacker_gearbox.sv
// mipi_rx_raw_unpacker_gearbox
// Unpacks LANES-byte MIPI CSI-2 payload words into beats of 4 pixels
// (RAW8/10/12/14) through a byte-granular gearbox.
// Ports:
//   clk_i           clock
//   reset_i         synchronous active-high reset
//   data_valid_i    payload valid, high for the whole packet
//   data_i          payload bytes, data_i[7:0] earliest in stream order
//   packet_type_i   data type: 2=RAW8, 3=RAW10, 4=RAW12, 5=RAW14
//   output_valid_o  output beat valid
//   output_o        4 MSB-aligned pixels, pixel 0 in the top slot
//   pixel_count_o   pixels emitted in current/last packet (saturating)
//   packet_error_o  pulse: packet ended with a partial group buffered
module mipi_rx_raw_unpacker_gearbox #(
  parameter int LANES    = 4,
  parameter int OUT_BITS = 16
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  data_valid_i,
  input  logic [8*LANES-1:0]    data_i,
  input  logic [2:0]            packet_type_i,
  output logic                  output_valid_o,
  output logic [4*OUT_BITS-1:0] output_o,
  output logic [15:0]           pixel_count_o,
  output logic                  packet_error_o
);

  if (!(LANES == 1 || LANES == 2 || LANES == 4)) begin : g_bad_lanes
    $error("LANES must be 1, 2 or 4");
  end
  if (OUT_BITS < 14) begin : g_bad_out_bits
    $error("OUT_BITS must be at least 14");
  end

  typedef enum logic [1:0] {IDLE = 2'd0, ACTIVE = 2'd1, DROP = 2'd2} state_t;

  function automatic logic is_raw(input logic [2:0] t);
    return (t >= 3'd2) && (t <= 3'd5);
  endfunction

  // Bytes per 4-pixel group.
  function automatic logic [4:0] group_bytes(input logic [2:0] t);
    case (t)
      3'd3:    return 5'd5;
      3'd4:    return 5'd6;
      3'd5:    return 5'd7;
      default: return 5'd4;
    endcase
  endfunction

  // Turns one group (b0 in the low byte) into 4 MSB-aligned pixel slots.
  function automatic logic [4*OUT_BITS-1:0] unpack(input logic [2:0] t, input logic [55:0] b);
    logic [7:0]          by [7];
    logic [13:0]         v  [4];
    logic [23:0]         l;
    logic [4*OUT_BITS-1:0] r;
    for (int i = 0; i < 7; i++) by[i] = b[8*i +: 8];
    l = {by[6], by[5], by[4]};
    case (t)
      3'd3: for (int k = 0; k < 4; k++) v[k] = {by[k], by[4][2*k +: 2], 4'b0000};
      3'd4: begin
        v[0] = {by[0], by[2][3:0], 2'b00};
        v[1] = {by[1], by[2][7:4], 2'b00};
        v[2] = {by[3], by[5][3:0], 2'b00};
        v[3] = {by[4], by[5][7:4], 2'b00};
      end
      3'd5: for (int k = 0; k < 4; k++) v[k] = {by[k], l[6*k +: 6]};
      default: for (int k = 0; k < 4; k++) v[k] = {by[k], 6'b000000};
    endcase
    r = '0;
    for (int k = 0; k < 4; k++) r[(4-k)*OUT_BITS-1 -: OUT_BITS] = OUT_BITS'(v[k]) << (OUT_BITS - 14);
    return r;
  endfunction

  // Input stage copies
  logic               valid_q;
  logic [8*LANES-1:0] data_q;
  logic [2:0]         type_q;

  state_t state_q, state_d;
  logic [2:0]   mode_q, mode_d, mode_eff_s;
  logic [127:0] buf_q, buf_d, merged_s;
  logic [4:0]   cnt_q, cnt_d, fill_s, grp_s;
  logic         start_s, accept_s, flush_s;
  logic         beat_q, beat_d;
  logic [55:0]  beat_bytes_q, beat_bytes_d;
  logic [2:0]   beat_mode_q;
  logic         err_d;
  logic                  out_valid_q, out_valid_d;
  logic [4*OUT_BITS-1:0] out_q, out_d;
  logic [15:0]           pc_q, pc_d, pc_base_s;
  logic [16:0]           pc_sum_s;
  logic                  perr_q;

  // Input registers keep sampling through reset so that DROP sees the
  // true valid level and discards a packet already in flight.
  always_ff @(posedge clk_i) begin
    valid_q <= data_valid_i;
    data_q  <= data_i;
    type_q  <= packet_type_i;
  end

  // Packet FSM next state and mode latch
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    case (state_q)
      IDLE: begin
        if (valid_q) begin
          if (is_raw(type_q)) begin
            state_d = ACTIVE;
            mode_d  = type_q;
          end else begin
            state_d = DROP;
          end
        end else begin
          state_d = IDLE;
        end
      end
      ACTIVE: begin
        if (!valid_q) state_d = IDLE;
        else          state_d = ACTIVE;
      end
      DROP: begin
        if (!valid_q) state_d = IDLE;
        else          state_d = DROP;
      end
      default: state_d = DROP;
    endcase
  end

  // The first word of a packet is accepted in IDLE, so the mode comes
  // straight from the registered type on that cycle.
  assign start_s    = (state_q == IDLE) && valid_q && is_raw(type_q);
  assign accept_s   = valid_q && ((state_q == ACTIVE) || start_s);
  assign flush_s    = (state_q == ACTIVE) && !valid_q;
  assign mode_eff_s = (state_q == IDLE) ? type_q : mode_q;
  assign grp_s      = group_bytes(mode_eff_s);
  assign fill_s     = cnt_q + 5'(LANES);
  // Bytes above cnt_q are kept zero, so OR-ing appends the new word.
  assign merged_s   = buf_q | (128'(data_q) << {cnt_q, 3'b000});

  // Gearbox append/consume and flush
  always_comb begin
    buf_d        = buf_q;
    cnt_d        = cnt_q;
    beat_d       = 1'b0;
    beat_bytes_d = beat_bytes_q;
    err_d        = 1'b0;
    if (accept_s) begin
      if (fill_s >= grp_s) begin
        beat_d       = 1'b1;
        beat_bytes_d = merged_s[55:0];
        buf_d        = merged_s >> {grp_s, 3'b000};
        cnt_d        = fill_s - grp_s;
      end else begin
        buf_d = merged_s;
        cnt_d = fill_s;
      end
    end else if (flush_s) begin
      err_d = (cnt_q != 5'd0);
      buf_d = '0;
      cnt_d = 5'd0;
    end else begin
      buf_d = buf_q;
      cnt_d = cnt_q;
    end
  end

  // Output stage: unpack the staged group and maintain the pixel counter
  always_comb begin
    pc_base_s   = start_s ? 16'd0 : pc_q;
    pc_sum_s    = {1'b0, pc_base_s} + 17'd4;
    out_valid_d = beat_q;
    if (beat_q) begin
      out_d = unpack(beat_mode_q, beat_bytes_q);
      pc_d  = pc_sum_s[16] ? 16'hFFFF : pc_sum_s[15:0];
    end else begin
      out_d = out_q;
      pc_d  = pc_base_s;
    end
  end

  // State, gearbox, staging and output registers
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q      <= DROP;
      mode_q       <= 3'd2;
      buf_q        <= '0;
      cnt_q        <= 5'd0;
      beat_q       <= 1'b0;
      beat_bytes_q <= 56'd0;
      beat_mode_q  <= 3'd2;
      out_valid_q  <= 1'b0;
      out_q        <= '0;
      pc_q         <= 16'd0;
      perr_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      mode_q       <= mode_d;
      buf_q        <= buf_d;
      cnt_q        <= cnt_d;
      beat_q       <= beat_d;
      beat_bytes_q <= beat_bytes_d;
      beat_mode_q  <= mode_eff_s;
      out_valid_q  <= out_valid_d;
      out_q        <= out_d;
      pc_q         <= pc_d;
      perr_q       <= err_d;
    end
  end

  assign output_valid_o = out_valid_q;
  assign output_o       = out_q;
  assign pixel_count_o  = pc_q;
  assign packet_error_o = perr_q;

endmodule

// File: tb/tb_mipi_rx_raw_unpacker_gearbox.sv
// Bench for mipi_rx_raw_unpacker_gearbox with three instances (LANES=4,1,2).
// A stream-level model turns each packet's bytes into a cycle-indexed schedule
// of expected beats/errors; a compare process checks every cycle.
module tb_mipi_rx_raw_unpacker_gearbox;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        rst  [3];
  logic        vin  [3];
  logic [2:0]  tin  [3];
  logic [31:0] d4;
  logic [7:0]  d1;
  logic [15:0] d2;
  logic        ov   [3];
  logic [63:0] oo   [3];
  logic [15:0] opc  [3];
  logic        oe   [3];

  mipi_rx_raw_unpacker_gearbox #(.LANES(4), .OUT_BITS(16)) dut4 (
    .clk_i(clk), .reset_i(rst[0]), .data_valid_i(vin[0]), .data_i(d4), .packet_type_i(tin[0]),
    .output_valid_o(ov[0]), .output_o(oo[0]), .pixel_count_o(opc[0]), .packet_error_o(oe[0]));
  mipi_rx_raw_unpacker_gearbox #(.LANES(1), .OUT_BITS(16)) dut1 (
    .clk_i(clk), .reset_i(rst[1]), .data_valid_i(vin[1]), .data_i(d1), .packet_type_i(tin[1]),
    .output_valid_o(ov[1]), .output_o(oo[1]), .pixel_count_o(opc[1]), .packet_error_o(oe[1]));
  mipi_rx_raw_unpacker_gearbox #(.LANES(2), .OUT_BITS(16)) dut2 (
    .clk_i(clk), .reset_i(rst[2]), .data_valid_i(vin[2]), .data_i(d2), .packet_type_i(tin[2]),
    .output_valid_o(ov[2]), .output_o(oo[2]), .pixel_count_o(opc[2]), .packet_error_o(oe[2]));

  int pass_cnt = 0;
  int tot_cnt  = 0;

  task automatic chk(input string nm, input int idx, input logic [63:0] act, input logic [63:0] exp);
    tot_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s[dut%0d] cyc %0d: got %h expected %h", nm, idx, cyc, act, exp);
  endtask

  // Expected schedule, key = idx*1000000 + edge number after which it is visible
  logic [63:0] exp_o   [int];
  bit          exp_e   [int];
  bit          exp_clr [int];
  bit          exp_rst [int];

  logic [63:0] hold_o [3];
  logic [15:0] pc_m   [3];
  logic [63:0] last_o [3];
  int          last_cyc [3];
  int          beats [3];
  int          errs  [3];
  bit          cmp_en = 1'b0;

  int pkt[$];
  int pad[$];
  int start_cyc;

  function automatic int lanes_of(input int idx);
    return (idx == 0) ? 4 : (idx == 1) ? 1 : 2;
  endfunction

  // 4 pixels of group g of pad[] for data type t, from the pixel formulas
  function automatic logic [63:0] model_beat(input logic [2:0] t, input int g);
    int b[7];
    int p[4];
    int n, bsz, l;
    logic [63:0] r;
    bsz = int'(t) + 2;
    for (int i = 0; i < 7; i++) b[i] = (i < bsz && g*bsz + i < pad.size()) ? pad[g*bsz + i] : 0;
    n = 8;
    for (int k = 0; k < 4; k++) p[k] = 0;
    case (t)
      3'd2: begin n = 8;  for (int k = 0; k < 4; k++) p[k] = b[k]; end
      3'd3: begin n = 10; for (int k = 0; k < 4; k++) p[k] = b[k]*4 + ((b[4] >> (2*k)) & 3); end
      3'd4: begin
        n = 12;
        p[0] = b[0]*16 + (b[2] & 15); p[1] = b[1]*16 + (b[2] >> 4);
        p[2] = b[3]*16 + (b[5] & 15); p[3] = b[4]*16 + (b[5] >> 4);
      end
      3'd5: begin
        n = 14; l = b[4] + b[5]*256 + b[6]*65536;
        for (int k = 0; k < 4; k++) p[k] = b[k]*64 + ((l >> (6*k)) & 63);
      end
      default: n = 8;
    endcase
    r = 64'd0;
    for (int k = 0; k < 4; k++) r = {r[47:0], 16'(p[k] << (16 - n))};
    return r;
  endfunction

  task automatic drive(input int idx, input bit v, input logic [2:0] t, input int base);
    int ln;
    ln = lanes_of(idx);
    vin[idx] = v;
    tin[idx] = t;
    for (int l = 0; l < ln; l++) begin
      case (idx)
        0:       d4[8*l +: 8] = v ? 8'(pad[base + l]) : 8'h00;
        1:       d1           = v ? 8'(pad[base + l]) : 8'h00;
        default: d2[8*l +: 8] = v ? 8'(pad[base + l]) : 8'h00;
      endcase
    end
  endtask

  // Sends pkt[] (zero-padded to whole words) as one packet and, when
  // model_on, schedules the expected beats, error and count clear.
  task automatic send_pkt(input int idx, input logic [2:0] t, input bit model_on);
    int ln, ncyc, total, bsz, s, key;
    ln = lanes_of(idx);
    pad = pkt;
    while (pad.size() % ln != 0) pad.push_back(0);
    total = pad.size();
    ncyc  = total / ln;
    bsz   = int'(t) + 2;
    for (int j = 0; j < ncyc; j++) begin
      @(negedge clk);
      if (j == 0) begin
        s = cyc + 1;
        start_cyc = s;
        if (model_on && t >= 3'd2 && t <= 3'd5) begin
          exp_clr[idx*1000000 + s + 1] = 1'b1;
          for (int g = 0; (g + 1)*bsz <= total; g++) begin
            key = idx*1000000 + s + ((g + 1)*bsz - 1) / ln + 2;
            exp_o[key] = model_beat(t, g);
          end
          if (total % bsz != 0) exp_e[idx*1000000 + s + ncyc + 1] = 1'b1;
        end
      end
      drive(idx, 1'b1, t, j*ln);
    end
    @(negedge clk);
    drive(idx, 1'b0, t, 0);
  endtask

  // Per-cycle comparison of all instances against the schedule
  always @(negedge clk) begin
    if (cmp_en) begin
      for (int idx = 0; idx < 3; idx++) begin
        int key;
        bit ev;
        key = idx*1000000 + cyc;
        if (exp_rst.exists(key)) begin hold_o[idx] = 64'd0; pc_m[idx] = 16'd0; end
        if (exp_clr.exists(key)) pc_m[idx] = 16'd0;
        ev = exp_o.exists(key);
        if (ev) begin
          hold_o[idx] = exp_o[key];
          pc_m[idx] = (pc_m[idx] > 16'hFFFB) ? 16'hFFFF : pc_m[idx] + 16'd4;
        end
        chk("valid", idx, 64'(ov[idx]), 64'(ev));
        chk("pixels", idx, oo[idx], hold_o[idx]);
        chk("error", idx, 64'(oe[idx]), 64'(exp_e.exists(key)));
        chk("count", idx, 64'(opc[idx]), 64'(pc_m[idx]));
        if (ov[idx]) begin last_o[idx] = oo[idx]; last_cyc[idx] = cyc; beats[idx]++; end
        if (oe[idx]) errs[idx]++;
      end
    end
  end

  int b0, e0;

  initial begin
    for (int i = 0; i < 3; i++) begin
      rst[i] = 1'b1; vin[i] = 1'b0; tin[i] = 3'd0;
      hold_o[i] = 64'd0; pc_m[i] = 16'd0; last_o[i] = 64'd0;
      last_cyc[i] = 0; beats[i] = 0; errs[i] = 0;
    end
    d4 = 32'd0; d1 = 8'd0; d2 = 16'd0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) rst[i] = 1'b0;
    cmp_en = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset_valid", 0, 64'(ov[0]), 64'd0);
    chk("reset_pixels", 0, oo[0], 64'd0);
    chk("reset_count", 0, 64'(opc[0]), 64'd0);
    chk("reset_error", 0, 64'(oe[0]), 64'd0);

    // 1: RAW10 single group with 3 leftover bytes
    b0 = beats[0]; e0 = errs[0];
    pkt = '{8'h12, 8'h34, 8'h56, 8'h78, 8'hE4};
    send_pkt(0, 3'd3, 1'b1);
    repeat (4) @(negedge clk);
    chk("t1_beat", 0, last_o[0], 64'h1200_3440_5680_78C0);
    chk("t1_count", 0, 64'(opc[0]), 64'd4);
    chk("t1_nbeats", 0, 64'(beats[0] - b0), 64'd1);
    chk("t1_nerr", 0, 64'(errs[0] - e0), 64'd1);

    // 2: RAW12 first beat and its latency
    pkt = '{8'hAB, 8'hCD, 8'h21, 8'h11, 8'h22, 8'h43};
    send_pkt(0, 3'd4, 1'b1);
    repeat (4) @(negedge clk);
    chk("t2_beat", 0, last_o[0], 64'hAB10_CD20_1130_2240);
    chk("t2_latency", 0, 64'(last_cyc[0] - start_cyc), 64'd3);

    // 3: RAW10, 20 bytes in 5 cycles, four gapless beats
    b0 = beats[0]; e0 = errs[0];
    pkt.delete();
    for (int i = 0; i < 20; i++) pkt.push_back((i*37 + 5) & 255);
    send_pkt(0, 3'd3, 1'b1);
    repeat (4) @(negedge clk);
    chk("t3_nbeats", 0, 64'(beats[0] - b0), 64'd4);
    chk("t3_nerr", 0, 64'(errs[0] - e0), 64'd0);
    chk("t3_count", 0, 64'(opc[0]), 64'd16);

    // 4: RAW8 on one lane
    pkt = '{8'h01, 8'h02, 8'h03, 8'h04};
    send_pkt(1, 3'd2, 1'b1);
    repeat (4) @(negedge clk);
    chk("t4_beat", 1, last_o[1], 64'h0100_0200_0300_0400);
    chk("t4_latency", 1, 64'(last_cyc[1] - start_cyc), 64'd5);
    chk("t4_count", 1, 64'(opc[1]), 64'd4);

    // 5: unsupported data type for 10 cycles
    b0 = beats[0]; e0 = errs[0];
    pkt.delete();
    for (int i = 0; i < 40; i++) pkt.push_back(i);
    send_pkt(0, 3'd6, 1'b1);
    repeat (4) @(negedge clk);
    chk("t5_nbeats", 0, 64'(beats[0] - b0), 64'd0);
    chk("t5_nerr", 0, 64'(errs[0] - e0), 64'd0);
    chk("t5_count", 0, 64'(opc[0]), 64'd16);

    // 6: RAW14 on two lanes; a normal packet, then reset mid-packet
    pkt = '{8'hFF, 8'h00, 8'hFF, 8'h00, 8'h3F, 8'hF0, 8'h03,
            8'hFF, 8'h00, 8'hFF, 8'h00, 8'h3F, 8'hF0, 8'h03};
    send_pkt(2, 3'd5, 1'b1);
    repeat (4) @(negedge clk);
    chk("t6_pre_count", 2, 64'(opc[2]), 64'd8);
    b0 = beats[2]; e0 = errs[2];
    pad.delete();
    for (int i = 0; i < 16; i++) pad.push_back(8'h11 + i);
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      if (j == 0) exp_clr[2*1000000 + cyc + 2] = 1'b1;
      drive(2, 1'b1, 3'd5, 2*j);
    end
    @(negedge clk);
    rst[2] = 1'b1;
    exp_rst[2*1000000 + cyc + 1] = 1'b1;
    drive(2, 1'b1, 3'd5, 8);
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      rst[2] = 1'b0;
      drive(2, 1'b1, 3'd5, 10 + 2*j);
    end
    @(negedge clk);
    drive(2, 1'b0, 3'd5, 0);
    repeat (4) @(negedge clk);
    chk("t6_rst_nbeats", 2, 64'(beats[2] - b0), 64'd0);
    chk("t6_rst_nerr", 2, 64'(errs[2] - e0), 64'd0);
    chk("t6_rst_pixels", 2, oo[2], 64'd0);
    b0 = beats[2]; e0 = errs[2];
    pkt = '{8'hFF, 8'h00, 8'hFF, 8'h00, 8'h3F, 8'hF0, 8'h03};
    send_pkt(2, 3'd5, 1'b1);
    repeat (4) @(negedge clk);
    chk("t6_beat", 2, last_o[2], 64'hFFFC_0000_FFFC_0000);
    chk("t6_count", 2, 64'(opc[2]), 64'd4);
    chk("t6_nbeats", 2, 64'(beats[2] - b0), 64'd1);
    chk("t6_nerr", 2, 64'(errs[2] - e0), 64'd1);

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule
